noc_rx_accumulator: RTL and testbench
=====================================

// Module: noc_rx_accumulator
// PURPOSE
//  Receive-side stage between a NoC router adapter's master AXI-stream port and downstream user logic.
//  Buffers incoming beats in a small FIFO and accumulates each packet into one wide sum.
//  A packet ends on tlast or after MAX_BEATS beats. Emits {sum, beat count} on a ready/valid output.
//  Exerts real backpressure on the adapter (s_tready), unlike a free-running accumulator.
// PARAMETERS
//  NOC_DW      32  input beat width (bits)
//  ACC_W       34  accumulator/output sum width; must be >= NOC_DW
//  FIFO_DEPTH  4   input FIFO entries; power of 2, >= 2
//  MAX_BEATS   16  forced packet close after this many beats; >= 1
// PORTS
//  clk       in   1                       clock, all logic on posedge
//  reset     in   1                       asynchronous, active-low reset
//  s_tdata   in   NOC_DW                  beat from adapter master_tdata
//  s_tvalid  in   1                       beat valid
//  s_tlast   in   1                       last beat of packet
//  s_tready  out  1                       FIFO can accept a beat
//  m_tdata   out  ACC_W                   packet sum
//  m_tcount  out  $clog2(MAX_BEATS+1)     beats in packet
//  m_tsat    out  1                       sum saturated; tied 0 without macro
//  m_tvalid  out  1                       result valid
//  m_tready  in   1                       consumer accepts result
// BEHAVIOUR
//  Reset (reset=0, async): FIFO empty, state ACCUM, sum=0, count=0.
//   Output reset values: s_tready=1, m_tvalid=0, m_tdata=0, m_tcount=0, m_tsat=0.
//  Input: s_tready = !fifo_full (registered; no same-cycle pass-through when full).
//   Push on s_tvalid & s_tready. Stores {tlast, tdata}.
//  FSM ACCUM
//   Pop 1 entry per cycle while FIFO not empty.
//   sum += zero-extended tdata, truncated to ACC_W. count += 1.
//   If popped tlast = 1, or count+1 == MAX_BEATS: latch the result to m_* and go to EMIT.
//  FSM EMIT
//   m_tvalid = 1. m_tdata/m_tcount/m_tsat stay stable; no pops. FIFO still accepts until full.
//   On m_tvalid & m_tready: clear sum/count/sat and go to ACCUM (m_tvalid=0 next cycle).
//  Latency: a tlast beat pushed at edge k is popped at edge k+1; m_tvalid=1 after edge k+1.
//  Throughput: 1 beat/cycle within a packet; 1 idle pop cycle per packet (EMIT).
//  Boundaries
//   FIFO full: s_tready=0, adapter holds its beat.
//   Push and pop in the same cycle: occupancy unchanged.
//   Pointers wrap modulo FIFO_DEPTH; full/empty use an extra wrap bit.
//   Sum overflow: wraps modulo 2^ACC_W (see CONFIGURATION).
//   Zero-length packets are impossible: a packet always contains its tlast beat.
//   Reset mid-packet: partial sum and FIFO contents are discarded.
// CONFIGURATION
//  NOC_RX_ACC_SATURATE_EN
//   defined: the sum clamps at 2^ACC_W-1. m_tsat=1 for a packet in which any add overflowed.
//   undefined: the sum wraps. m_tsat is a constant 0. No saturation logic.
// STRUCTURE
//  Package noc_rx_pkg: NOC_DW default, state enum {ACCUM, EMIT}, FIFO entry struct {last, data}.
//  Sub-module noc_rx_fifo: parameterised sync FIFO (DEPTH, WIDTH).
//   Ports: push/pop/full/empty/dout. Async active-low reset.
//  Top: FSM, accumulator, output registers.
// TESTING
//  1 Reset: hold reset=0 3 cycles -> s_tready=1, m_tvalid=0, m_tdata=0, m_tcount=0.
//  2 Packet 1,2,3 (tlast on 3), m_tready=1 -> one result m_tdata=6, m_tcount=3;
//    m_tvalid rises 1 cycle after the tlast push.
//  3 No tlast, 17 beats of 1 -> first result sum=16 count=16 (MAX_BEATS close);
//    next packet starts with the 17th beat.
//  4 m_tready=0 during EMIT while streaming -> s_tready drops after 4 more pushes.
//    Result held stable; release m_tready -> all buffered beats accumulate; no loss or duplication.
//  5 Five beats 0xFFFFFFFF, tlast on 5th -> without macro m_tdata=0x0FFFFFFFB, m_tsat=0;
//    with NOC_RX_ACC_SATURATE_EN m_tdata=0x3FFFFFFFF, m_tsat=1.
//  6 Assert reset after 2 of 4 beats, then send packet 7 (tlast)
//    -> result sum=7 count=1; the partial packet is gone.

Source files
------------

// File: rtl/noc_rx_pkg.sv
// Shared types for the NoC receive accumulator: default beat width, FSM states
// and the FIFO entry layout.
package noc_rx_pkg;

  localparam int NOC_DW_DEFAULT = 32;

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_e;

  // Entry at the default beat width; the top re-declares it at its own NOC_DW.
  typedef struct packed {
    logic                     last;
    logic [NOC_DW_DEFAULT-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/noc_rx_if.sv
// Beat-in / result-out bundle of the NoC receive accumulator.
// slave = accumulator side, master = adapter/consumer side.
interface noc_rx_if #(
  parameter int NOC_DW = 32,
  parameter int ACC_W  = 34,
  parameter int CNT_W  = 5
);
  logic [NOC_DW-1:0] s_tdata;
  logic              s_tvalid;
  logic              s_tlast;
  logic              s_tready;
  logic [ACC_W-1:0]  m_tdata;
  logic [CNT_W-1:0]  m_tcount;
  logic              m_tsat;
  logic              m_tvalid;
  logic              m_tready;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tcount, m_tsat, m_tvalid
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tcount, m_tsat, m_tvalid
  );
endinterface

// File: rtl/noc_rx_fifo.sv
// Synchronous FIFO, DEPTH a power of 2; pointers carry an extra wrap bit so
// full and empty are distinguishable. Push when full / pop when empty are ignored.
module noc_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             do_push, do_pop;

  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty   = (wr_q == rd_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/noc_rx_accumulator.sv
// Buffers NoC beats and sums each packet (closed by tlast or MAX_BEATS beats)
// into one {sum, count} result. NOC_RX_ACC_SATURATE_EN selects clamping sums.
module noc_rx_accumulator
  import noc_rx_pkg::*;
#(
  parameter int NOC_DW     = NOC_DW_DEFAULT,
  parameter int ACC_W      = 34,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BEATS  = 16
) (
  input  logic     clk,
  input  logic     reset,
  noc_rx_if.slave  bus
);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef struct packed {
    logic              last;
    logic [NOC_DW-1:0] data;
  } entry_t;

  entry_t           din, dout;
  logic             fifo_full, fifo_empty, pop;
  state_e           state_q, state_d;
  logic [ACC_W-1:0] sum_q, sum_d, nsum;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [ACC_W-1:0] mdata_q, mdata_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  always_comb begin
    din      = '0;
    din.last = bus.s_tlast;
    din.data = bus.s_tdata;
  end

  noc_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(entry_t))) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.s_tvalid),
    .din   (din),
    .pop   (pop),
    .dout  (dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pop     = (state_q == ACCUM) && !fifo_empty;
  assign cnt_inc = cnt_q + 1'b1;

`ifdef NOC_RX_ACC_SATURATE_EN
  logic [ACC_W:0] add_full;
  logic           sat_q, sat_d, nsat, msat_q, msat_d;

  assign add_full = {1'b0, sum_q} + (ACC_W+1)'(dout.data);
  assign nsum     = add_full[ACC_W] ? '1 : add_full[ACC_W-1:0];
  assign nsat     = sat_q | add_full[ACC_W];
  assign bus.m_tsat = msat_q;
`else
  assign nsum       = sum_q + ACC_W'(dout.data);
  assign bus.m_tsat = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    mdata_d = mdata_q;
    mcnt_d  = mcnt_q;
`ifdef NOC_RX_ACC_SATURATE_EN
    sat_d   = sat_q;
    msat_d  = msat_q;
`endif
    case (state_q)
      ACCUM: begin
        if (pop) begin
          sum_d = nsum;
          cnt_d = cnt_inc;
`ifdef NOC_RX_ACC_SATURATE_EN
          sat_d = nsat;
`endif
          if (dout.last || cnt_inc == CNT_W'(MAX_BEATS)) begin
            mdata_d = nsum;
            mcnt_d  = cnt_inc;
`ifdef NOC_RX_ACC_SATURATE_EN
            msat_d  = nsat;
`endif
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        // Result registers keep their value after the handshake; only the
        // running accumulator is cleared for the next packet.
        if (bus.m_tready) begin
          sum_d   = '0;
          cnt_d   = '0;
`ifdef NOC_RX_ACC_SATURATE_EN
          sat_d   = 1'b0;
`endif
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ACCUM;
      sum_q   <= '0;
      cnt_q   <= '0;
      mdata_q <= '0;
      mcnt_q  <= '0;
`ifdef NOC_RX_ACC_SATURATE_EN
      sat_q   <= 1'b0;
      msat_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      mdata_q <= mdata_d;
      mcnt_q  <= mcnt_d;
`ifdef NOC_RX_ACC_SATURATE_EN
      sat_q   <= sat_d;
      msat_q  <= msat_d;
`endif
    end
  end

  assign bus.s_tready = !fifo_full;
  assign bus.m_tvalid = (state_q == EMIT);
  assign bus.m_tdata  = mdata_q;
  assign bus.m_tcount = mcnt_q;
endmodule

// File: tb/tb_noc_rx_accumulator.sv
// Directed bench for noc_rx_accumulator; inputs driven 1ns after posedge,
// results captured on negedge when a handshake is about to happen.
module tb_noc_rx_accumulator;
  localparam int NOC_DW = 32;
  localparam int ACC_W  = 34;
  localparam int CNT_W  = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  noc_rx_if #(.NOC_DW(NOC_DW), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  noc_rx_accumulator #(
    .NOC_DW(NOC_DW), .ACC_W(ACC_W), .FIFO_DEPTH(4), .MAX_BEATS(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [63:0] q_sum[$];
  logic [63:0] q_cnt[$];
  logic [63:0] q_sat[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one beat and hold it until accepted.
  task automatic send(input logic [31:0] d, input logic l);
    int n;
    bus.s_tdata  = d;
    bus.s_tlast  = l;
    bus.s_tvalid = 1'b1;
    n = 0;
    while (!bus.s_tready && n < 200) begin
      tick(1);
      n++;
    end
    if (n >= 200) chk("send_timeout", 64'd0, 64'd1);
    tick(1);
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
  endtask

  task automatic res(input string tag, input logic [63:0] sum, input logic [63:0] cnt,
                     input logic [63:0] sat);
    if (q_sum.size() == 0) begin
      chk({tag, "_present"}, 64'd0, 64'd1);
    end else begin
      chk({tag, "_sum"}, q_sum.pop_front(), sum);
      chk({tag, "_cnt"}, q_cnt.pop_front(), cnt);
      chk({tag, "_sat"}, q_sat.pop_front(), sat);
    end
  endtask

  always @(negedge clk) begin
    if (reset && bus.m_tvalid && bus.m_tready) begin
      q_sum.push_back(64'(bus.m_tdata));
      q_cnt.push_back(64'(bus.m_tcount));
      q_sat.push_back(64'(bus.m_tsat));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    bus.s_tdata  = '0;
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    bus.m_tready = 1'b1;
    tick(3);
    chk("rst_s_tready", 64'(bus.s_tready), 64'd1);
    chk("rst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
    chk("rst_m_tdata",  64'(bus.m_tdata),  64'd0);
    chk("rst_m_tcount", 64'(bus.m_tcount), 64'd0);
    chk("rst_m_tsat",   64'(bus.m_tsat),   64'd0);
    reset = 1'b1;
    tick(1);

    // 1+2+3, result one cycle after the tlast push
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    send(32'd3, 1'b1);
    chk("lat_not_yet", 64'(bus.m_tvalid), 64'd0);
    tick(1);
    chk("lat_valid",  64'(bus.m_tvalid), 64'd1);
    chk("lat_tdata",  64'(bus.m_tdata),  64'd6);
    chk("lat_tcount", 64'(bus.m_tcount), 64'd3);
    tick(3);
    res("pkt123", 64'd6, 64'd3, 64'd0);

    // 17 beats without tlast: forced close at 16, 17th opens next packet
    for (int i = 0; i < 17; i++) send(32'd1, 1'b0);
    tick(4);
    res("max16", 64'd16, 64'd16, 64'd0);
    chk("max16_only_one", 64'(q_sum.size()), 64'd0);
    send(32'd5, 1'b1);
    tick(4);
    res("after_max", 64'd6, 64'd2, 64'd0);

    // Consumer stalls during EMIT: FIFO fills, result held, then drains
    bus.m_tready = 1'b0;
    send(32'd10, 1'b0);
    send(32'd20, 1'b1);
    for (int i = 1; i <= 4; i++) send(32'(i), 1'b0);
    chk("bp_s_tready", 64'(bus.s_tready), 64'd0);
    chk("bp_m_tvalid", 64'(bus.m_tvalid), 64'd1);
    chk("bp_m_tdata",  64'(bus.m_tdata),  64'd30);
    chk("bp_m_tcount", 64'(bus.m_tcount), 64'd2);
    fork
      send(32'd5, 1'b1);
      begin
        tick(3);
        chk("bp_hold_s_tready", 64'(bus.s_tready), 64'd0);
        chk("bp_hold_m_tdata",  64'(bus.m_tdata),  64'd30);
        chk("bp_hold_m_tvalid", 64'(bus.m_tvalid), 64'd1);
        bus.m_tready = 1'b1;
      end
    join
    tick(8);
    res("held",  64'd30, 64'd2, 64'd0);
    res("drain", 64'd15, 64'd5, 64'd0);
    chk("drain_no_dup", 64'(q_sum.size()), 64'd0);

    // Overflow: five all-ones beats
    for (int i = 0; i < 5; i++) send(32'hFFFF_FFFF, (i == 4));
    tick(4);
`ifdef NOC_RX_ACC_SATURATE_EN
    res("ovf", 64'h3_FFFF_FFFF, 64'd5, 64'd1);
`else
    res("ovf", 64'h0_FFFF_FFFB, 64'd5, 64'd0);
`endif

    // Reset mid-packet discards the partial packet and buffered beats
    send(32'd11, 1'b0);
    send(32'd12, 1'b0);
    reset = 1'b0;
    tick(2);
    chk("mid_rst_s_tready", 64'(bus.s_tready), 64'd1);
    chk("mid_rst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
    chk("mid_rst_m_tdata",  64'(bus.m_tdata),  64'd0);
    reset = 1'b1;
    tick(1);
    send(32'd7, 1'b1);
    tick(4);
    res("post_reset", 64'd7, 64'd1, 64'd0);
    chk("post_reset_only_one", 64'(q_sum.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
